// File: rtl/bin2bcd_scan_pkg.sv
// Shared display definitions for the binary-to-BCD front end of the seven-segment path.
// These are the FSM encodings and the code the digit decoder renders as a dark digit.
package bin2bcd_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } conv_state_e;

    localparam logic [3:0] BLANK_CODE = 4'hF;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the next shift.
module bcd_add3
    import bin2bcd_scan_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    // Correct one digit ahead of the left shift; 4-bit wrap is intentional.
    always_comb begin
        if (digit_in >= 4'd5) begin
            digit_out = digit_in + 4'd3;
        end else begin
            digit_out = digit_in;
        end
    end

endmodule

// File: rtl/bin2bcd_scan.sv
// Sequential shift-and-add-3 binary-to-BCD converter with optional leading-zero blanking.
// One conversion takes WIDTH shift cycles plus one finish cycle; the result is held until the next one.
module bin2bcd_scan
    import bin2bcd_scan_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd_out
);

    localparam int SW = DIGITS * 4;
    localparam int CW = $clog2(WIDTH + 1);

    conv_state_e       state_r;
    conv_state_e       state_next_s;
    logic              busy_r;
    logic              done_r;
    logic              busy_next_s;
    logic              done_next_s;
    logic [WIDTH-1:0]  bin_r;
    logic [SW-1:0]     scratch_r;
    logic [SW-1:0]     corr_s;
    logic [SW-1:0]     blank_s;
    logic [SW-1:0]     bcd_r;
    logic [CW-1:0]     cnt_r;
    logic              blank_r;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .digit_in  (scratch_r[4*g +: 4]),
                .digit_out (corr_s[4*g +: 4])
            );
        end
    endgenerate

    // State register together with the registered status outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= busy_next_s;
            done_r  <= done_next_s;
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CW'(1)) begin
                    state_next_s = ST_FINISH;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_FINISH: state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Status outputs: busy follows the upcoming state, done marks the FINISH edge.
    always_comb begin
        busy_next_s = 1'b0;
        done_next_s = 1'b0;
        case (state_r)
            ST_IDLE:   busy_next_s = (state_next_s != ST_IDLE);
            ST_SHIFT:  busy_next_s = 1'b1;
            ST_FINISH: done_next_s = 1'b1;
            default: begin
                busy_next_s = 1'b0;
                done_next_s = 1'b0;
            end
        endcase
    end

    // Leading-zero scan from the top digit down; digit 0 always shows, interior zeros stay.
    always_comb begin : blank_scan
        logic lead_v;
        blank_s = scratch_r;
        lead_v  = blank_r;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (lead_v && (scratch_r[4*k +: 4] == 4'd0)) begin
                blank_s[4*k +: 4] = BLANK_CODE;
            end else begin
                lead_v = 1'b0;
            end
        end
    end

    // Conversion datapath: load on accept, correct-then-shift in SHIFT, publish in FINISH.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bin_r     <= '0;
            scratch_r <= '0;
            cnt_r     <= '0;
            blank_r   <= 1'b0;
            bcd_r     <= {DIGITS{BLANK_CODE}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        bin_r     <= bin_in;
                        blank_r   <= blank_lz;
                        scratch_r <= '0;
                        cnt_r     <= CW'(WIDTH);
                    end else begin
                        bin_r     <= bin_r;
                    end
                end
                ST_SHIFT: begin
                    scratch_r <= {corr_s[SW-2:0], bin_r[WIDTH-1]};
                    bin_r     <= bin_r << 1;
                    cnt_r     <= cnt_r - CW'(1);
                end
                ST_FINISH: begin
                    bcd_r <= blank_s;
                end
                default: begin
                    bcd_r <= bcd_r;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign bcd_out = bcd_r;

endmodule

// File: tb/tb_bin2bcd_scan.sv
// Self-checking bench for bin2bcd_scan (WIDTH=8, DIGITS=3): scoreboard of expected results
// popped on every done pulse, plus a held-value check on every other cycle.
module tb_bin2bcd_scan;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [7:0]  bin_in;
    logic        blank_lz;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;

    int          checks;
    int          errors;
    bit          mon_en;
    logic [11:0] exp_hold;
    logic [11:0] sb[$];

    bin2bcd_scan #(.WIDTH(8), .DIGITS(3)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .bin_in   (bin_in),
        .blank_lz (blank_lz),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [11:0] ref_bcd(input int v, input bit blz);
        logic [3:0] d2, d1, d0;
        d2 = 4'(v / 100);
        d1 = 4'((v / 10) % 10);
        d0 = 4'(v % 10);
        if (blz && d2 == 4'd0) begin
            d2 = 4'hF;
            if (d1 == 4'd0) d1 = 4'hF;
        end
        return {d2, d1, d0};
    endfunction

    // Scoreboard monitor: a done cycle must carry the oldest expected result, other cycles hold.
    always @(negedge clock) begin
        if (mon_en) begin
            checks++;
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: bcd_out=%h with no conversion pending", bcd_out);
                end else begin
                    exp_hold = sb.pop_front();
                    if (bcd_out !== exp_hold) begin
                        errors++;
                        $display("FAIL result: got %h expected %h", bcd_out, exp_hold);
                    end
                end
            end else if (bcd_out !== exp_hold) begin
                errors++;
                $display("FAIL held_value: got %h expected %h", bcd_out, exp_hold);
            end
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic start_conv(input int v, input bit blz);
        bin_in   = 8'(v);
        blank_lz = blz;
        start    = 1'b1;
        sb.push_back(ref_bcd(v, blz));
        step();
        start    = 1'b0;
        bin_in   = 8'($urandom_range(0, 255));
        blank_lz = 1'($urandom_range(0, 1));
    endtask

    // Steps until done is seen, checking busy meanwhile; cyc counts edges taken.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_during_conv: got %b expected 1 at step %0d", busy, cyc);
            end
            step();
            cyc++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", cyc);
        end else if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_in_done: got %b expected 0", busy);
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        start    = 1'b1;
        bin_in   = 8'd55;
        blank_lz = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (bcd_out !== 12'hFFF || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: bcd=%h busy=%b done=%b expected fff/0/0", bcd_out, busy, done);
            end
        end
        exp_hold = 12'hFFF;
        mon_en   = 1'b1;
        reset_n  = 1'b1;
        start    = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_ignored: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_basic();
        int c;
        start_conv(255, 1'b0);
        wait_done(c);
        checks++;
        if (c != 9) begin
            errors++;
            $display("FAIL latency_255: got %0d expected 9", c);
        end
        repeat (3) step();
    endtask

    task automatic test_blanking();
        int vals[4] = '{7, 0, 105, 40};
        int c;
        foreach (vals[i]) begin
            start_conv(vals[i], 1'b1);
            wait_done(c);
            checks++;
            if (c != 9) begin
                errors++;
                $display("FAIL latency_blank: value %0d got %0d expected 9", vals[i], c);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        int c;
        start_conv(200, 1'b0);
        step();
        step();
        bin_in   = 8'd99;
        blank_lz = 1'b1;
        start    = 1'b1;
        step();
        start    = 1'b0;
        wait_done(c);
        checks++;
        if (c != 6) begin
            errors++;
            $display("FAIL ignored_start_latency: got %0d expected 6", c);
        end
        start_conv(77, 1'b1);
        wait_done(c);
        checks++;
        if (c != 9) begin
            errors++;
            $display("FAIL done_cycle_start: got %0d expected 9", c);
        end
        step();
    endtask

    task automatic test_abort();
        int c;
        start_conv(150, 1'b0);
        repeat (4) step();
        reset_n = 1'b0;
        sb.delete();
        exp_hold = 12'hFFF;
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 12'hFFF) begin
            errors++;
            $display("FAIL abort_state: bcd=%h busy=%b done=%b expected fff/0/0", bcd_out, busy, done);
        end
        reset_n = 1'b1;
        repeat (12) step();
        start_conv(128, 1'b0);
        wait_done(c);
        checks++;
        if (c != 9) begin
            errors++;
            $display("FAIL post_abort_latency: got %0d expected 9", c);
        end
        step();
    endtask

    task automatic test_sweep();
        int c;
        for (int v = 0; v < 256; v++) begin
            start_conv(v, 1'b0);
            wait_done(c);
            checks++;
            if (c != 9) begin
                errors++;
                $display("FAIL sweep_latency: value %0d got %0d expected 9", v, c);
            end
        end
        repeat (3) step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sweep_drain: %0d results never appeared, expected 0", sb.size());
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        mon_en   = 1'b0;
        exp_hold = 12'hFFF;
        reset_n  = 1'b0;
        start    = 1'b0;
        bin_in   = 8'd0;
        blank_lz = 1'b0;
        test_reset();
        test_basic();
        test_blanking();
        test_back_to_back();
        test_abort();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
